md_adder_stim_checker: RTL

- Drives the 3-input / 2-bit-sum adder lab block from the other side of its port list.
- Generates the IN_A/IN_B/IN_D stimulus, captures the returned OUT_E sum and OUT_A0 echo, and checks them against an internal reference model.
- Sits beside the adder on the FPGA board and reports PASS, error count and first failing vector to LEDs, so both the blocking and the nonblocking adder variants can be qualified in hardware.

---
 rtl/md_adder_stim_checker_if.sv | 25 ++
 rtl/md_adder_stim_checker.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/md_adder_stim_checker_if.sv
// Stimulus/response bundle between the adder stimulus checker and the adder under test.
// The master side is the checker; the slave side is the adder, the board LEDs and the START source.
interface md_adder_stim_checker_if;
  logic       START;
  logic       OUT_A;
  logic       OUT_B;
  logic       OUT_D;
  logic [1:0] IN_E;
  logic       IN_A0;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [3:0] ERR_CNT;
  logic [2:0] FIRST_ERR_VEC;

  modport master (
    input  START, IN_E, IN_A0,
    output OUT_A, OUT_B, OUT_D, BUSY, DONE, PASS, ERR_CNT, FIRST_ERR_VEC
  );

  modport slave (
    output START, IN_E, IN_A0,
    input  OUT_A, OUT_B, OUT_D, BUSY, DONE, PASS, ERR_CNT, FIRST_ERR_VEC
  );
endinterface

// File: rtl/md_adder_stim_checker.sv
// Drives all 8 vectors into a 3-input adder REPEAT times and checks the delayed sum.
// Optional macro ECHO_CHECK_EN adds a same-cycle check of the IN_A0 echo against OUT_A.
module md_adder_stim_checker #(
  parameter int unsigned DUT_LAT = 1,
  parameter int unsigned REPEAT  = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  md_adder_stim_checker_if.master bus
);

  localparam int unsigned Depth = DUT_LAT + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] vec;
    logic [1:0] expd;
  } pipe_t;

  state_e     state_q, state_d;
  logic [2:0] v_q, v_d;
  logic [3:0] pass_q, pass_d;
  logic [2:0] drain_q, drain_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic [2:0] first_q, first_d;
  logic       seen_q, seen_d;
  pipe_t      pipe_q [Depth];
  pipe_t      pipe_d [Depth];

  logic       start;
  logic       issue;
  logic [2:0] issue_vec;
  logic       sum_err;
  logic       err;
  logic [2:0] err_vec;
  pipe_t      tail;

  assign start = bus.START && (state_q == StIdle || state_q == StDone);
  assign tail  = pipe_q[DUT_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (bus.START) state_d = StRun;
      StRun:          if (pass_q == 4'(REPEAT)) state_d = StDrain;
      StDrain:        if (drain_q == 3'(DUT_LAT)) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.BUSY          = (state_q == StRun) || (state_q == StDrain);
    bus.DONE          = (state_q == StDone);
    bus.PASS          = (state_q == StDone) && (err_cnt_q == 4'd0);
    bus.OUT_A         = vec_q[2];
    bus.OUT_B         = vec_q[1];
    bus.OUT_D         = vec_q[0];
    bus.ERR_CNT       = err_cnt_q;
    bus.FIRST_ERR_VEC = first_q;
  end

  // Vector issue: the START edge itself drives v = 0, so RUN continues from v = 1.
  always_comb begin
    v_d       = v_q;
    pass_d    = pass_q;
    drain_d   = drain_q;
    issue     = 1'b0;
    issue_vec = v_q;
    if (start) begin
      issue     = 1'b1;
      issue_vec = 3'd0;
      v_d       = 3'd1;
      pass_d    = 4'd0;
      drain_d   = 3'd0;
    end else if (state_q == StRun && pass_q != 4'(REPEAT)) begin
      issue = 1'b1;
      v_d   = v_q + 3'd1;
      if (v_q == 3'd7) pass_d = pass_q + 4'd1;
    end else if (state_q == StDrain) begin
      drain_d = drain_q + 3'd1;
    end
    vec_d = issue ? issue_vec : 3'd0;
  end

  always_comb begin
    pipe_d[0].valid = issue;
    pipe_d[0].vec   = issue_vec;
    pipe_d[0].expd  = {1'b0, issue_vec[2]} + {1'b0, issue_vec[1]} + {1'b0, issue_vec[0]};
    for (int unsigned i = 1; i < Depth; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  assign sum_err = tail.valid && (tail.expd != bus.IN_E);

`ifdef ECHO_CHECK_EN
  logic echo_err;
  assign echo_err = (state_q == StRun) && (bus.IN_A0 != vec_q[2]);
  assign err      = sum_err || echo_err;
  assign err_vec  = sum_err ? tail.vec : vec_q;
`else
  assign err      = sum_err;
  assign err_vec  = tail.vec;
`endif

  always_comb begin
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    seen_d    = seen_q;
    if (start) begin
      err_cnt_d = 4'd0;
      first_d   = 3'd0;
      seen_d    = 1'b0;
    end else if (err) begin
      if (err_cnt_q != 4'd15) err_cnt_d = err_cnt_q + 4'd1;
      if (!seen_q) begin
        first_d = err_vec;
        seen_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= 3'd0;
      pass_q    <= 4'd0;
      drain_q   <= 3'd0;
      vec_q     <= 3'd0;
      err_cnt_q <= 4'd0;
      first_q   <= 3'd0;
      seen_q    <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      v_q       <= v_d;
      pass_q    <= pass_d;
      drain_q   <= drain_d;
      vec_q     <= vec_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      seen_q    <= seen_d;
      for (int unsigned i = 0; i < Depth; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

endmodule
